// File: rtl/pc_pkg.sv
// Shared types and default sizing for the program-counter sequencer.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_INC  = 2'b00,
    PC_JUMP = 2'b01,
    PC_CALL = 2'b10,
    PC_RET  = 2'b11
  } next_sel_t;

  localparam int PC_ADDR_W    = 8;
  localparam int PC_RAS_DEPTH = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. When the stack is full, a push overwrites the oldest entry.
// A pop on an empty stack changes nothing except setting the sticky underflow flag.
module pc_ras #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         ovf,
  output logic         unf
);

  localparam int SP_W  = $clog2(DEPTH);
  localparam int CNT_W = SP_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [SP_W-1:0]  r_sp;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_unf;

  logic [SP_W-1:0]  w_top_idx;
  logic             w_empty;
  logic             w_full;

  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CNT_W'(DEPTH));
  // r_sp always points at the next free slot. When the stack is full, that slot holds the oldest entry.
  assign w_top_idx = r_sp - 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_sp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (push) begin
      r_mem[r_sp] <= data_in;
      r_sp        <= r_sp + 1'b1;
      if (w_full) r_ovf <= 1'b1;
      else        r_cnt <= r_cnt + 1'b1;
    end else if (pop) begin
      if (w_empty) begin
        r_unf <= 1'b1;
      end else begin
        r_sp  <= r_sp - 1'b1;
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign top   = r_mem[w_top_idx];
  assign empty = w_empty;
  assign full  = w_full;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

endmodule

// File: rtl/pc_seq.sv
// Fetch-stage PC sequencer: stall hold, and INC/JUMP/CALL/RET next-PC selection.
// The return-address stack is built only when PC_RAS_EN is defined.
module pc_seq
  import pc_pkg::*;
#(
  parameter int               ADDR_W    = PC_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int               RAS_DEPTH = PC_RAS_DEPTH
) (
  input  logic              CLK,
  input  logic              areset_n,
  input  logic              stall,
  input  logic [1:0]        next_sel,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] addr_out,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_unf
);

  if (ADDR_W < 2) begin : g_bad_addr_w
    $error("pc_seq: ADDR_W must be at least 2");
  end
  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pc_seq: RAS_DEPTH must be a power of two, at least 2");
  end

  next_sel_t         w_sel;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc_next;

  assign w_sel    = next_sel_t'(next_sel);
  assign w_pc_inc = r_pc + 1'b1;

`ifdef PC_RAS_EN
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_ras_top;

  // Stack updates are gated by stall, so a stalled cycle changes neither the PC nor the stack.
  assign w_push = !stall && (w_sel == PC_CALL);
  assign w_pop  = !stall && (w_sel == PC_RET);

  pc_ras #(
    .W     (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (CLK),
    .rst_n   (areset_n),
    .push    (w_push),
    .pop     (w_pop),
    .data_in (w_pc_inc),
    .top     (w_ras_top),
    .empty   (ras_empty),
    .full    (ras_full),
    .ovf     (ras_ovf),
    .unf     (ras_unf)
  );

  always_comb begin
    w_pc_next = w_pc_inc;
    case (w_sel)
      PC_JUMP: w_pc_next = target;
      PC_CALL: w_pc_next = target;
      PC_RET:  w_pc_next = ras_empty ? w_pc_inc : w_ras_top;
      default: w_pc_next = w_pc_inc;
    endcase
  end
`else
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_ovf   = 1'b0;
  assign ras_unf   = 1'b0;

  always_comb begin
    w_pc_next = w_pc_inc;
    case (w_sel)
      PC_JUMP: w_pc_next = target;
      PC_CALL: w_pc_next = target;
      default: w_pc_next = w_pc_inc;
    endcase
  end
`endif

  always_ff @(posedge CLK or negedge areset_n) begin
    if (!areset_n)   r_pc <= RESET_VEC;
    else if (!stall) r_pc <= w_pc_next;
  end

  assign addr_out = r_pc;

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq: a queue-based stack model predicts each cycle and a monitor checks the DUT.
// Directed steps also carry a fixed expected PC taken from the worked examples.
module tb_pc_seq;

  localparam int         ADDR_W    = 8;
  localparam int         DEPTH     = 4;
  localparam logic [7:0] RV        = 8'h10;
`ifdef PC_RAS_EN
  localparam bit         RAS_EN    = 1'b1;
`else
  localparam bit         RAS_EN    = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       areset_n = 1'b1;
  logic       stall = 1'b1;
  logic [1:0] next_sel = 2'b00;
  logic [7:0] target = 8'h00;
  logic [7:0] addr_out;
  logic       ras_empty, ras_full, ras_ovf, ras_unf;

  pc_seq #(
    .ADDR_W    (ADDR_W),
    .RESET_VEC (RV),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .CLK       (CLK),
    .areset_n  (areset_n),
    .stall     (stall),
    .next_sel  (next_sel),
    .target    (target),
    .addr_out  (addr_out),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] pc;
    logic       emp;
    logic       ful;
    logic       ovf;
    logic       unf;
    int         want;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: the stack is a plain queue, with the newest entry at the back.
  int         m_pc;
  logic [7:0] m_stk[$];
  bit         m_ovf, m_unf;

  function automatic void model_apply(input logic [1:0] sel, input logic [7:0] tgt);
    case (sel)
      2'b00: m_pc = (m_pc + 1) % 256;
      2'b01: m_pc = tgt;
      2'b10: begin
        if (RAS_EN) begin
          if (m_stk.size() == DEPTH) begin
            void'(m_stk.pop_front());
            m_ovf = 1'b1;
          end
          m_stk.push_back(8'((m_pc + 1) % 256));
        end
        m_pc = tgt;
      end
      default: begin
        if (RAS_EN && m_stk.size() > 0) begin
          m_pc = m_stk.pop_back();
        end else begin
          if (RAS_EN) m_unf = 1'b1;
          m_pc = (m_pc + 1) % 256;
        end
      end
    endcase
  endfunction

  function automatic void push_exp(input int want);
    exp_t e;
    e.pc   = 8'(m_pc);
    e.emp  = (m_stk.size() == 0);
    e.ful  = (m_stk.size() == DEPTH);
    e.ovf  = m_ovf;
    e.unf  = m_unf;
    e.want = want;
    q.push_back(e);
  endfunction

  task automatic step(input logic [1:0] sel, input logic [7:0] tgt, input bit stl, input int want);
    @(negedge CLK);
    next_sel = sel;
    target   = tgt;
    stall    = stl;
    if (!stl) model_apply(sel, tgt);
    push_exp(want);
  endtask

  // Reset is asserted between clock edges so that its asynchronous effect can be observed.
  task automatic do_reset();
    @(negedge CLK);
    #2;
    stall = 1'b1;
    m_pc  = RV;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    push_exp(RV);
    areset_n = 1'b0;
    @(negedge CLK);
    areset_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK or negedge areset_n);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if ({addr_out, ras_empty, ras_full, ras_ovf, ras_unf} !== {e.pc, e.emp, e.ful, e.ovf, e.unf}) begin
          n_bad++;
          $display("FAIL state t=%0t: got pc=%h emp=%b full=%b ovf=%b unf=%b, want pc=%h emp=%b full=%b ovf=%b unf=%b",
                   $time, addr_out, ras_empty, ras_full, ras_ovf, ras_unf, e.pc, e.emp, e.ful, e.ovf, e.unf);
        end
        if (e.want >= 0) begin
          n_vec++;
          if (addr_out !== 8'(e.want)) begin
            n_bad++;
            $display("FAIL plan_pc t=%0t: got %h, want %h", $time, addr_out, 8'(e.want));
          end
        end
      end
    end
  end

  initial begin : driver
    int budget;
    // 1: reset and increment, then an asynchronous reset in the middle of the sequence
    do_reset();
    step(2'b00, 8'h00, 1'b0, 'h11);
    step(2'b00, 8'h00, 1'b0, 'h12);
    step(2'b00, 8'h00, 1'b0, 'h13);
    do_reset();
    step(2'b00, 8'h00, 1'b0, 'h11);
    // 2: jump near the top of the range, wrap to 0, then stall
    step(2'b01, 8'hFE, 1'b0, 'hFE);
    step(2'b00, 8'h00, 1'b0, 'hFF);
    step(2'b00, 8'h00, 1'b0, 'h00);
    step(2'b10, 8'h77, 1'b1, 'h00);
    step(2'b01, 8'h55, 1'b1, 'h00);
    // 3: nested call/return
    step(2'b01, 8'h20, 1'b0, 'h20);
    step(2'b10, 8'h40, 1'b0, 'h40);
    step(2'b00, 8'h00, 1'b0, 'h41);
    step(2'b10, 8'h60, 1'b0, 'h60);
    step(2'b11, 8'h00, 1'b0, RAS_EN ? 'h42 : 'h61);
    step(2'b11, 8'h00, 1'b0, RAS_EN ? 'h21 : 'h62);
    // 4: overflow, where the fifth call overwrites the oldest return address
    do_reset();
    step(2'b01, 8'h00, 1'b0, 'h00);
    for (int i = 1; i <= 5; i++) step(2'b10, 8'(i * 16), 1'b0, i * 16);
    for (int i = 4; i >= 1; i--) step(2'b11, 8'h00, 1'b0, RAS_EN ? (i * 16 + 1) : ('h50 + 5 - i));
    // 5: return on an empty stack
    do_reset();
    step(2'b01, 8'h33, 1'b0, 'h33);
    step(2'b11, 8'h00, 1'b0, 'h34);
    step(2'b00, 8'h00, 1'b0, 'h35);
    step(2'b10, 8'h80, 1'b0, 'h80);
    step(2'b11, 8'h00, 1'b0, RAS_EN ? 'h36 : 'h81);
    // random traffic, with occasional resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(99) < 2) do_reset();
      else step(2'($urandom_range(3)), 8'($urandom_range(255)), $urandom_range(9) < 2, -1);
    end
    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(negedge CLK);
      budget++;
    end
    if (q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
